legv8_multicycle_controller: RTL and testbench

- Multi-cycle FSM that sequences the LEGv8 datapath by driving its 34-bit ControlWord and 64-bit constant each cycle.
- Fetches an instruction into IR, decodes `IR_out`, then issues 1–3 execute micro-ops before advancing the PC.
- Sits between the datapath and the top level; it is the only driver of ControlWord in the CPU.

---
 rtl/legv8_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_legv8_multicycle_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_controller.sv
// legv8_multicycle_controller
// Multi-cycle sequencer for the LEGv8 datapath. Each cycle it presents a
// registered 34-bit control word and a 64-bit extended immediate.
// Every instruction is fetched into IR and decoded, then runs 1-3 execute
// micro-ops before the PC advances.
//
// Optional feature, macro WARTHOG_MEM_WAIT_EN:
//   When defined, S_FETCH and S_MEM hold their control word until mem_ready=1.
//   The datapath must then qualify its write enables with mem_ready.
//   When undefined, mem_ready is ignored and memory is single-cycle.
//
// Handshake: there is none in the valid/ready sense. mem_ready is a level
// completion strobe. Under the macro, the state advances on the first rising
// edge at which mem_ready=1 while in S_FETCH or S_MEM.
//
// The control word is computed from next_state and then registered, so it is
// valid for the whole cycle in which that state is current.

module legv8_multicycle_controller #(
   parameter int RESET_VECTOR_SEL = 0,
   parameter int Z_BIT            = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] IR_out,
   input  logic [4:0]  status,
   input  logic        mem_ready,
   output logic [33:0] ControlWord,
   output logic [63:0] constant,
   output logic [3:0]  state,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM    = 4'd4,
      S_CBTEST = 4'd5,
      S_CBBR   = 4'd6,
      S_PCINC  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      K_RTYPE, K_ITYPE, K_LOAD, K_STORE, K_B, K_CBZ, K_BAD
   } kind_t;

   typedef struct packed {
      logic       pc_addr;
      logic       mem_oe;
      logic       mem_cs;
      logic [1:0] pc_sel;
      logic       pc_ld;
      logic       b_sel;
      logic       ir_ld;
      logic       status_ld;
      logic [4:0] fs;
      logic       c0;
      logic [1:0] fixed;
      logic       mem_we;
      logic       reg_we;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
   } cw_t;

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;

   localparam cw_t NOP_WORD = '{fixed: 2'b11, default: '0};
   // Reset-vector load: PC <- input bus with SA=31.
   localparam cw_t VEC_WORD = '{fixed: 2'b11, pc_sel: 2'b10, pc_ld: 1'b1,
                                sa: 5'd31, default: '0};

   state_t      state_q, next_state;
   cw_t         cw_q, cw_n;
   logic [63:0] const_q, const_n;
   logic        z_q, z_n;
   logic        illegal_q, illegal_n;
   logic        halted_q;

   kind_t       kind;
   logic [4:0]  dec_fs;
   logic        dec_c0;
   logic [63:0] dec_const;
   logic        mem_go;
   logic        unused_ok;

   logic [4:0] rd, rn, rm;
   assign rd = IR_out[4:0];
   assign rn = IR_out[9:5];
   assign rm = IR_out[20:16];

`ifdef WARTHOG_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   assign mem_go = 1'b1;
`endif

   // Only the zero flag of status is consumed; mem_ready is idle by default.
   assign unused_ok = &{1'b0, status, mem_ready};

   // Opcode classification, ALU function select and immediate extension.
   always_comb begin
      kind      = K_BAD;
      dec_fs    = FS_ADD;
      dec_c0    = 1'b0;
      dec_const = '0;
      if (IR_out[31:21] == 11'b10001011000) begin
         kind = K_RTYPE; dec_fs = FS_ADD;
      end else if (IR_out[31:21] == 11'b11001011000) begin
         kind = K_RTYPE; dec_fs = FS_SUB; dec_c0 = 1'b1;
      end else if (IR_out[31:21] == 11'b10001010000) begin
         kind = K_RTYPE; dec_fs = FS_AND;
      end else if (IR_out[31:21] == 11'b10101010000) begin
         kind = K_RTYPE; dec_fs = FS_ORR;
      end else if (IR_out[31:22] == 10'b1001000100) begin
         kind = K_ITYPE; dec_fs = FS_ADD;
         dec_const = {52'd0, IR_out[21:10]};
      end else if (IR_out[31:22] == 10'b1101000100) begin
         kind = K_ITYPE; dec_fs = FS_SUB; dec_c0 = 1'b1;
         dec_const = {52'd0, IR_out[21:10]};
      end else if (IR_out[31:21] == 11'b11111000010) begin
         kind = K_LOAD;
         dec_const = {{55{IR_out[20]}}, IR_out[20:12]};
      end else if (IR_out[31:21] == 11'b11111000000) begin
         kind = K_STORE;
         dec_const = {{55{IR_out[20]}}, IR_out[20:12]};
      end else if (IR_out[31:26] == 6'b000101) begin
         kind = K_B;
         dec_const = {{36{IR_out[25]}}, IR_out[25:0], 2'b00};
      end else if (IR_out[31:24] == 8'b10110100) begin
         kind = K_CBZ;
         dec_const = {{43{IR_out[23]}}, IR_out[23:5], 2'b00};
      end
   end

   // Next-state selection, then the control word for the state being entered.
   always_comb begin
      next_state = state_q;
      const_n    = const_q;
      z_n        = z_q;
      illegal_n  = illegal_q;
      cw_n       = NOP_WORD;

      case (state_q)
         S_IDLE:   if (run) next_state = S_FETCH;
         S_FETCH:  if (mem_go) next_state = S_DECODE;
         S_DECODE: begin
            const_n = dec_const;
            case (kind)
               K_RTYPE, K_ITYPE, K_B: next_state = S_EXEC;
               K_LOAD, K_STORE:       next_state = S_MEM;
               K_CBZ:                 next_state = S_CBTEST;
               default: begin
                  next_state = S_HALT;
                  illegal_n  = 1'b1;
               end
            endcase
         end
         S_EXEC:   next_state = (kind == K_B) ? S_FETCH : S_PCINC;
         S_MEM:    if (mem_go) next_state = S_PCINC;
         S_CBTEST: begin
            z_n        = status[Z_BIT];
            next_state = S_CBBR;
         end
         S_CBBR:   next_state = S_FETCH;
         S_PCINC:  next_state = run ? S_FETCH : S_IDLE;
         S_HALT:   next_state = S_HALT;
         default:  next_state = S_HALT;
      endcase

      case (next_state)
         S_FETCH: begin
            cw_n.pc_addr = 1'b1;
            cw_n.mem_oe  = 1'b1;
            cw_n.mem_cs  = 1'b1;
            cw_n.ir_ld   = 1'b1;
         end
         S_EXEC: begin
            if (kind == K_B) begin
               cw_n.pc_sel = 2'b11;
               cw_n.pc_ld  = 1'b1;
            end else begin
               cw_n.reg_we = 1'b1;
               cw_n.fs     = dec_fs;
               cw_n.c0     = dec_c0;
               cw_n.da     = rd;
               cw_n.sa     = rn;
               cw_n.sb     = (kind == K_ITYPE) ? 5'd0 : rm;
               cw_n.b_sel  = (kind == K_ITYPE);
            end
         end
         S_MEM: begin
            cw_n.b_sel  = 1'b1;
            cw_n.fs     = FS_ADD;
            cw_n.sa     = rn;
            cw_n.mem_cs = 1'b1;
            if (kind == K_LOAD) begin
               cw_n.mem_oe = 1'b1;
               cw_n.reg_we = 1'b1;
               cw_n.da     = rd;
            end else begin
               cw_n.mem_we = 1'b1;
               cw_n.sb     = rd;
            end
         end
         S_CBTEST: begin
            cw_n.fs        = FS_ADD;
            cw_n.sa        = rd;
            cw_n.sb        = 5'd31;
            cw_n.status_ld = 1'b1;
         end
         S_CBBR: begin
            cw_n.pc_ld  = 1'b1;
            cw_n.pc_sel = z_n ? 2'b11 : 2'b01;
         end
         S_PCINC: begin
            cw_n.pc_sel = 2'b01;
            cw_n.pc_ld  = 1'b1;
         end
         default: cw_n = NOP_WORD;
      endcase
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cw_q      <= (RESET_VECTOR_SEL != 0) ? VEC_WORD : NOP_WORD;
         const_q   <= '0;
         z_q       <= 1'b0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= next_state;
         cw_q      <= cw_n;
         const_q   <= const_n;
         z_q       <= z_n;
         illegal_q <= illegal_n;
         halted_q  <= (next_state == S_HALT);
      end
   end

   assign ControlWord = cw_q;
   assign constant    = const_q;
   assign state       = state_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// tb_legv8_multicycle_controller
// Directed stimulus with hand-computed control words and constants.
// Compile with +define+WARTHOG_MEM_WAIT_EN to exercise the memory wait states.

module tb_legv8_multicycle_controller;

   logic        clock;
   logic        reset;
   logic        run;
   logic [31:0] IR_out;
   logic [4:0]  status;
   logic        mem_ready;
   logic [33:0] ControlWord;
   logic [63:0] constant;
   logic [3:0]  state;
   logic        halted;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [33:0] NOP_W   = 34'h0_0006_0000;
   localparam logic [33:0] FETCH_W = 34'h3_8406_0000;

   legv8_multicycle_controller dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .IR_out      (IR_out),
      .status      (status),
      .mem_ready   (mem_ready),
      .ControlWord (ControlWord),
      .constant    (constant),
      .state       (state),
      .halted      (halted),
      .illegal     (illegal)
   );

   // Clock: 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bench-side encoding of a control word, MSB first.
   function automatic logic [33:0] cw(
      input logic pa, input logic oe, input logic cs, input logic [1:0] ps,
      input logic pl, input logic bs, input logic il, input logic sl,
      input logic [4:0] fs, input logic c0, input logic we, input logic rwe,
      input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
      return {pa, oe, cs, ps, pl, bs, il, sl, fs, c0, 2'b11, we, rwe, da, sa, sb};
   endfunction

   initial begin
      reset = 1'b0; run = 1'b0; IR_out = 32'h0; status = 5'd0; mem_ready = 1'b1;

      // Reset and idle
      tick(); tick();
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_cw", 64'(ControlWord), 64'(NOP_W));
      chk("rst_const", constant, 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      reset = 1'b1;
      tick(); tick(); tick();
      chk("idle_state", 64'(state), 64'd0);
      chk("idle_cw", 64'(ControlWord), 64'(NOP_W));

      // ADDI X0, X31, #24
      IR_out = 32'h910063E0; run = 1'b1;
      tick();
      chk("addi_fetch_state", 64'(state), 64'd1);
      chk("addi_fetch_cw", 64'(ControlWord), 64'(FETCH_W));
      tick();
      chk("addi_decode_state", 64'(state), 64'd2);
      chk("addi_decode_cw", 64'(ControlWord), 64'(NOP_W));
      tick();
      chk("addi_exec_state", 64'(state), 64'd3);
      chk("addi_exec_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b00,0,1,0,0,5'b01000,0,0,1,5'd0,5'd31,5'd0)));
      chk("addi_const", constant, 64'd24);
      tick();
      chk("addi_pcinc_state", 64'(state), 64'd7);
      chk("addi_pcinc_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b01,1,0,0,0,5'd0,0,0,0,5'd0,5'd0,5'd0)));

      // STUR X1, [X31, #-8]
      IR_out = {11'b11111000000, 9'h1F8, 2'b00, 5'd31, 5'd1};
      tick();
      chk("stur_fetch_state", 64'(state), 64'd1);
      tick(); tick();
      chk("stur_mem_state", 64'(state), 64'd4);
      chk("stur_mem_cw", 64'(ControlWord),
          64'(cw(0,0,1,2'b00,0,1,0,0,5'b01000,0,1,0,5'd0,5'd31,5'd1)));
      chk("stur_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      chk("stur_pcinc_state", 64'(state), 64'd7);

      // LDUR X2, [X31, #-8]
      IR_out = {11'b11111000010, 9'h1F8, 2'b00, 5'd31, 5'd2};
      tick(); tick(); tick();
      chk("ldur_mem_state", 64'(state), 64'd4);
      chk("ldur_mem_cw", 64'(ControlWord),
          64'(cw(0,1,1,2'b00,0,1,0,0,5'b01000,0,0,1,5'd2,5'd31,5'd0)));
      tick();

      // SUB X3, X4, X5
      IR_out = {11'b11001011000, 5'd5, 6'd0, 5'd4, 5'd3};
      tick(); tick(); tick();
      chk("sub_exec_state", 64'(state), 64'd3);
      chk("sub_exec_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b00,0,0,0,0,5'b01001,1,0,1,5'd3,5'd4,5'd5)));
      tick();
      chk("sub_pcinc_state", 64'(state), 64'd7);

      // CBZ X7, #12 taken
      IR_out = {8'b10110100, 19'd3, 5'd7};
      status = 5'b00001;
      tick(); tick(); tick();
      chk("cbz_t_test_state", 64'(state), 64'd5);
      chk("cbz_t_test_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b00,0,0,0,1,5'b01000,0,0,0,5'd0,5'd7,5'd31)));
      chk("cbz_t_const", constant, 64'd12);
      tick();
      chk("cbz_t_br_state", 64'(state), 64'd6);
      chk("cbz_t_br_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b11,1,0,0,0,5'd0,0,0,0,5'd0,5'd0,5'd0)));
      tick();
      chk("cbz_t_next_fetch", 64'(state), 64'd1);

      // CBZ X7, #-8 not taken
      IR_out = {8'b10110100, 19'h7FFFE, 5'd7};
      status = 5'b00000;
      tick(); tick();
      chk("cbz_n_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      chk("cbz_n_br_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b01,1,0,0,0,5'd0,0,0,0,5'd0,5'd0,5'd0)));
      tick();

      // B #-4: PC step skipped
      IR_out = {6'b000101, 26'h3FF_FFFF};
      tick(); tick();
      chk("b_exec_state", 64'(state), 64'd3);
      chk("b_exec_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b11,1,0,0,0,5'd0,0,0,0,5'd0,5'd0,5'd0)));
      chk("b_const", constant, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("b_skip_pcinc", 64'(state), 64'd1);

      // AND X1, X2, X3 then stop running
      IR_out = {11'b10001010000, 5'd3, 6'd0, 5'd2, 5'd1};
      tick(); tick();
      chk("and_exec_cw", 64'(ControlWord),
          64'(cw(0,0,0,2'b00,0,0,0,0,5'b00000,0,0,1,5'd1,5'd2,5'd3)));
      run = 1'b0;
      tick(); tick();
      chk("stop_idle_state", 64'(state), 64'd0);

      // Illegal opcode
      IR_out = 32'hFFFF_FFFF; run = 1'b1;
      tick(); tick(); tick();
      chk("ill_state", 64'(state), 64'd8);
      chk("ill_halted", 64'(halted), 64'd1);
      chk("ill_illegal", 64'(illegal), 64'd1);
      chk("ill_cw", 64'(ControlWord), 64'(NOP_W));
      tick(); tick(); tick();
      chk("ill_sticky_state", 64'(state), 64'd8);
      chk("ill_sticky_halted", 64'(halted), 64'd1);
      reset = 1'b0; run = 1'b0;
      tick();
      chk("ill_rst_state", 64'(state), 64'd0);
      chk("ill_rst_halted", 64'(halted), 64'd0);
      chk("ill_rst_illegal", 64'(illegal), 64'd0);
      reset = 1'b1;

      // Reset in the middle of a store
      IR_out = {11'b11111000000, 9'h1F8, 2'b00, 5'd31, 5'd1}; run = 1'b1;
      tick(); tick(); tick();
      chk("mid_mem_state", 64'(state), 64'd4);
      chk("mid_mem_we", 64'(ControlWord[16]), 64'd1);
      reset = 1'b0;
      tick();
      chk("mid_rst_state", 64'(state), 64'd0);
      chk("mid_rst_cw", 64'(ControlWord), 64'(NOP_W));
      reset = 1'b1; run = 1'b0;
      tick();
      chk("mid_after_state", 64'(state), 64'd0);

      // Memory wait states on fetch
      run = 1'b1; mem_ready = 1'b0;
      tick();
      chk("wait_fetch_state", 64'(state), 64'd1);
`ifdef WARTHOG_MEM_WAIT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_hold_state", 64'(state), 64'd1);
         chk("wait_hold_cw", 64'(ControlWord), 64'(FETCH_W));
      end
      mem_ready = 1'b1;
      tick();
      chk("wait_release_state", 64'(state), 64'd2);
`else
      tick();
      chk("nowait_decode_state", 64'(state), 64'd2);
      mem_ready = 1'b1;
`endif
      run = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
